// File: rtl/swap_pkg.sv
// Shared definitions for the swap-sort sequencer: FSM state encoding and
// default bus widths that must agree with the swap register file.
package swap_pkg;

    localparam int ADDRESS_WIDTH_DEF = 7;
    localparam int DATA_WIDTH_DEF    = 8;
    localparam int COUNT_WIDTH_DEF   = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_SWAP = 3'd3,
        ST_DONE = 3'd4
    } sort_state_t;

endpackage

// File: rtl/swap_sort_compare.sv
// Combinational out-of-order detector for one adjacent element pair.
// Equal values are never reported out of order, so the sort is stable.
module swap_sort_compare
    import swap_pkg::*;
#(
    parameter int data_width = DATA_WIDTH_DEF
) (
    input  logic [data_width-1:0] a,
    input  logic [data_width-1:0] b,
    input  logic                  descending,
    output logic                  out_of_order
);

    // Strict unsigned compare in the requested direction
    always_comb begin
        out_of_order = descending ? (a < b) : (a > b);
    end

endmodule

// File: rtl/swap_sort_sequencer.sv
// Bubble-sort controller for the swap register file. Walks the window
// [lo_addr, hi_addr] reading adjacent pairs and issuing one-cycle swap
// commands. Optional macro SWAP_SORT_EARLY_EXIT_EN ends the run after the
// first pass that performed no swap; without it every pass always runs.
module swap_sort_sequencer
    import swap_pkg::*;
#(
    parameter int address_width = ADDRESS_WIDTH_DEF,
    parameter int data_width    = DATA_WIDTH_DEF,
    parameter int count_width   = COUNT_WIDTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [address_width-1:0] lo_addr,
    input  logic [address_width-1:0] hi_addr,
    input  logic                     descending,
    output logic                     busy,
    output logic                     done,
    output logic [count_width-1:0]   swap_count,
    output logic [address_width-1:0] address_r,
    input  logic [data_width-1:0]    data_r,
    output logic [address_width-1:0] address_a,
    output logic [address_width-1:0] address_b,
    output logic                     swap
);

    localparam logic [address_width-1:0] ADDR_ONE  = {{(address_width-1){1'b0}}, 1'b1};
    localparam logic [count_width-1:0]   COUNT_ONE = {{(count_width-1){1'b0}}, 1'b1};

    sort_state_t r_state;
    sort_state_t w_next_state;

    logic [address_width-1:0] r_i;
    logic [address_width-1:0] r_last;
    logic [address_width-1:0] r_lo;
    logic                     r_desc;
    logic                     r_swapped;
    logic [data_width-1:0]    r_data_a;
    logic [count_width-1:0]   r_swap_count;
    logic [address_width-1:0] r_addr_a;
    logic [address_width-1:0] r_addr_b;

    logic [address_width-1:0] w_i_next;
    logic [address_width-1:0] w_last_dec;
    logic                     w_out_of_order;
    logic                     w_advance;
    logic                     w_pass_end;
    logic                     w_pass_swapped;
    logic                     w_finish;
    logic                     w_accept;

    assign w_i_next       = r_i + ADDR_ONE;
    assign w_last_dec     = r_last - ADDR_ONE;
    assign w_pass_end     = (w_i_next == r_last);
    assign w_pass_swapped = r_swapped | (r_state == ST_SWAP);
    assign w_accept       = (r_state == ST_IDLE) && start;

`ifdef SWAP_SORT_EARLY_EXIT_EN
    assign w_finish = (w_last_dec == r_lo) || !w_pass_swapped;
`else
    assign w_finish = (w_last_dec == r_lo);
`endif

    swap_sort_compare #(
        .data_width (data_width)
    ) u_compare (
        .a            (r_data_a),
        .b            (data_r),
        .descending   (r_desc),
        .out_of_order (w_out_of_order)
    );

    // State register; reset aborts a run immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, including the shared end-of-comparison advance step
    always_comb begin
        w_next_state = r_state;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (lo_addr >= hi_addr) ? ST_DONE : ST_RD_A;
                end
            end
            ST_RD_A: w_next_state = ST_RD_B;
            ST_RD_B: begin
                if (w_out_of_order) begin
                    w_next_state = ST_SWAP;
                end else begin
                    w_advance = 1'b1;
                end
            end
            ST_SWAP: w_advance = 1'b1;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        if (w_advance) begin
            w_next_state = (w_pass_end && w_finish) ? ST_DONE : ST_RD_A;
        end
    end

    // Datapath: window latch, pass bookkeeping, element latch and swap statistics
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i          <= '0;
            r_last       <= '0;
            r_lo         <= '0;
            r_desc       <= 1'b0;
            r_swapped    <= 1'b0;
            r_data_a     <= '0;
            r_swap_count <= '0;
            r_addr_a     <= '0;
            r_addr_b     <= '0;
        end else begin
            if (w_accept) begin
                r_lo         <= lo_addr;
                r_i          <= lo_addr;
                r_last       <= hi_addr;
                r_desc       <= descending;
                r_swapped    <= 1'b0;
                r_swap_count <= '0;
            end
            if (r_state == ST_RD_A) begin
                r_data_a <= data_r;
            end
            if ((r_state == ST_RD_B) && w_out_of_order) begin
                r_addr_a <= r_i;
                r_addr_b <= w_i_next;
            end
            if (r_state == ST_SWAP) begin
                r_swapped <= 1'b1;
                if (r_swap_count != '1) begin
                    r_swap_count <= r_swap_count + COUNT_ONE;
                end
            end
            if (w_advance) begin
                if (!w_pass_end) begin
                    r_i <= w_i_next;
                end else begin
                    r_last    <= w_last_dec;
                    r_i       <= r_lo;
                    r_swapped <= 1'b0;
                end
            end
        end
    end

    // Read address follows the pair under comparison, parks on lo otherwise
    always_comb begin
        address_r = r_lo;
        case (r_state)
            ST_RD_A: address_r = r_i;
            ST_RD_B: address_r = w_i_next;
            default: address_r = r_lo;
        endcase
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);
    assign swap       = (r_state == ST_SWAP);
    assign swap_count = r_swap_count;
    assign address_a  = r_addr_a;
    assign address_b  = r_addr_b;

endmodule

// File: tb/tb_swap_sort_sequencer.sv
// Testbench for swap_sort_sequencer with a behavioural swap register file and
// an array-based bubble-sort reference model.
module tb_swap_sort_sequencer;

    localparam int AW    = 7;
    localparam int DW    = 8;
    localparam int CW    = 16;
    localparam int DEPTH = 128;
`ifdef SWAP_SORT_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] lo_addr;
    logic [AW-1:0] hi_addr;
    logic          descending;
    logic          busy;
    logic          done;
    logic [CW-1:0] swap_count;
    logic [AW-1:0] address_r;
    logic [DW-1:0] data_r;
    logic [AW-1:0] address_a;
    logic [AW-1:0] address_b;
    logic          swap;

    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] image [DEPTH];
    logic [DW-1:0] model [DEPTH];
    logic          loadReq;

    int total     = 0;
    int bad       = 0;
    int doneCount = 0;
    int swapsSeen = 0;

    always #5 clk = ~clk;

    swap_sort_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .lo_addr    (lo_addr),
        .hi_addr    (hi_addr),
        .descending (descending),
        .busy       (busy),
        .done       (done),
        .swap_count (swap_count),
        .address_r  (address_r),
        .data_r     (data_r),
        .address_a  (address_a),
        .address_b  (address_b),
        .swap       (swap)
    );

    assign data_r = mem[address_r];

    // Register file: bulk load from the bench image, or commit a swap at the edge
    always @(posedge clk) begin
        if (loadReq) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= image[k];
        end else if (swap) begin
            mem[address_a] <= mem[address_b];
            mem[address_b] <= mem[address_a];
        end
    end

    // Observe done pulses and swap strobes; every swap must target an adjacent pair
    always @(negedge clk) begin
        logic [AW-1:0] nextA;
        if (done === 1'b1) doneCount++;
        if (swap === 1'b1) begin
            swapsSeen++;
            nextA = address_a + 7'd1;
            total++;
            assert (address_b === nextA) else begin
                bad++;
                $error("FAIL swapAdjacent observed=%0d expected=%0d", address_b, nextA);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Reference: plain bubble sort over the window, counting comparisons and swaps
    function automatic void modelSort(input int lo, input int hi, input bit desc,
                                      output int comps, output int swaps);
        logic [DW-1:0] t;
        bit            anySwap;
        comps = 0;
        swaps = 0;
        for (int last = hi; last > lo; last--) begin
            anySwap = 1'b0;
            for (int k = lo; k < last; k++) begin
                comps++;
                if (desc ? (model[k] < model[k+1]) : (model[k] > model[k+1])) begin
                    t          = model[k];
                    model[k]   = model[k+1];
                    model[k+1] = t;
                    swaps++;
                    anySwap = 1'b1;
                end
            end
            if (EARLY_EXIT && !anySwap) break;
        end
    endfunction

    task automatic loadImage();
        @(negedge clk);
        loadReq = 1'b1;
        @(negedge clk);
        loadReq = 1'b0;
    endtask

    // Start a run and count cycles from the sampling edge until done; optional start pulse mid-run
    task automatic applyStimulus(input int lo, input int hi, input bit desc, input int pulseAt,
                                 output int cycles);
        @(negedge clk);
        lo_addr    = AW'(lo);
        hi_addr    = AW'(hi);
        descending = desc;
        start      = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        cycles = 1;
        while (done !== 1'b1 && cycles < 2000) begin
            start = (cycles == pulseAt);
            if (cycles == pulseAt) begin
                lo_addr = 7'd0;
                hi_addr = 7'd3;
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        checkOutput("doneSeen", done, 1);
        checkOutput("busyAtDone", busy, 1);
    endtask

    task automatic runAndCheck(input string tag, input int lo, input int hi, input bit desc,
                               input int pulseAt);
        int comps, swaps, cycles, doneBefore, swapsBefore, wrong;
        for (int k = 0; k < DEPTH; k++) model[k] = image[k];
        modelSort(lo, hi, desc, comps, swaps);
        loadImage();
        doneBefore  = doneCount;
        swapsBefore = swapsSeen;
        applyStimulus(lo, hi, desc, pulseAt, cycles);
        checkOutput({tag, ".cycles"}, cycles, 2 * comps + swaps + 1);
        checkOutput({tag, ".swapCount"}, swap_count, swaps);
        @(negedge clk);
        checkOutput({tag, ".busyAfter"}, busy, 0);
        checkOutput({tag, ".donePulses"}, doneCount - doneBefore, 1);
        checkOutput({tag, ".swapStrobes"}, swapsSeen - swapsBefore, swaps);
        wrong = 0;
        for (int k = 0; k < DEPTH; k++) if (mem[k] !== model[k]) wrong++;
        checkOutput({tag, ".memory"}, wrong, 0);
    endtask

    initial begin
        int lo, len, cycles;
        bit desc;

        rst_n      = 1'b0;
        start      = 1'b0;
        lo_addr    = '0;
        hi_addr    = '0;
        descending = 1'b0;
        loadReq    = 1'b0;
        for (int k = 0; k < DEPTH; k++) image[k] = DW'(k);

        #12;
        checkOutput("rst.busy", busy, 0);
        checkOutput("rst.done", done, 0);
        checkOutput("rst.swap", swap, 0);
        checkOutput("rst.swapCount", swap_count, 0);
        checkOutput("rst.addressR", address_r, 0);
        checkOutput("rst.addressA", address_a, 0);
        checkOutput("rst.addressB", address_b, 0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] sorted window ascending");
        runAndCheck("sortedAsc", 20, 29, 1'b0, 0);

        $display("[TB] reversed window ascending");
        for (int k = 0; k < 5; k++) image[20+k] = DW'(24 - k);
        runAndCheck("reversedAsc", 20, 24, 1'b0, 0);

        runAndCheck("reversedDesc", 20, 24, 1'b1, 0);

        image[22] = 8'd5;
        image[23] = 8'd5;
        runAndCheck("equalAsc", 20, 24, 1'b0, 0);
        runAndCheck("equalDesc", 20, 24, 1'b1, 0);

        runAndCheck("degenerate", 22, 22, 1'b0, 0);
        runAndCheck("loAboveHi", 30, 25, 1'b0, 0);

        $display("[TB] start pulsed while busy");
        for (int k = 0; k < 5; k++) image[20+k] = DW'(24 - k);
        runAndCheck("startIgnored", 20, 24, 1'b0, 8);

        $display("[TB] random windows");
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < DEPTH; k++) image[k] = DW'($urandom_range(0, 255));
            lo   = $urandom_range(0, 110);
            len  = $urandom_range(2, 14);
            desc = 1'($urandom_range(0, 1));
            for (int k = lo; k < lo + len; k++) image[k] = DW'($urandom_range(0, 15));
            runAndCheck($sformatf("random%0d", r), lo, lo + len - 1, desc, 0);
        end

        $display("[TB] reset mid-run");
        for (int k = 0; k < DEPTH; k++) image[k] = DW'(k);
        for (int k = 0; k < 5; k++) image[20+k] = DW'(24 - k);
        loadImage();
        @(negedge clk);
        lo_addr    = 7'd20;
        hi_addr    = 7'd24;
        descending = 1'b0;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("midRun.swapBefore", swap, 1);
        checkOutput("midRun.busyBefore", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midRun.swap", swap, 0);
        checkOutput("midRun.busy", busy, 0);
        checkOutput("midRun.swapCount", swap_count, 0);
        checkOutput("midRun.done", done, 0);
        @(negedge clk);
        checkOutput("midRun.mem20", mem[20], 23);
        checkOutput("midRun.mem21", mem[21], 24);
        checkOutput("midRun.mem22", mem[22], 22);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midRun.idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
